mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one 4:1 multiplexer path among four requesters. It owns the mux select lines (`s1`, `s0`), grants one requester at a time with a bounded burst length, and registers the selected data onto a single shared output with a valid flag. The block sits in front of the 4:1 mux datapath, replacing free-running select stimulus with arbitrated, cycle-accurate selection.

## Interface
- `DATA_W`, default 1: width of each data input and of `y`.
- `MAX_BURST`, default 8: maximum consecutive grant cycles under contention. Legal range is 1..255.
- `clk` input, 1: sole clock. All state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `req` input, 4: request per requester. `req[0]` maps to `a`, `req[1]` to `b`, `req[2]` to `c`, `req[3]` to `d`. Held high while the requester wants the path.
- `a`, `b`, `c`, `d` input, DATA_W each: requester data. Mapping is `{s1,s0}` 00→`a`, 01→`b`, 10→`c`, 11→`d`.
- `gnt` output, 4: one-hot grant, registered; all-zero when idle.
- `s1`, `s0` output, 1 each: registered mux select equal to the encoded owner index.
- `y` output, DATA_W: registered mux output.
- `y_valid` output, 1: `y` carries owner data.

## Operation
- States:
  - IDLE: `gnt`=0.
  - BUSY: exactly one `gnt` bit set.
- Pointer `ptr` (2 bits) holds the highest-priority index. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4; the first requester with `req` high wins.
- IDLE → BUSY: any `req` bit high. Winner is granted, `{s1,s0}` is set to the winner index, and `cnt` is set to 1.
- BUSY, owner `o`, evaluated every cycle:
  - `req[o]`=0 (release): `ptr`←`o+1`. If any other `req` is high, grant the next winner immediately, with no bubble, and set `cnt`←1. Otherwise go to IDLE and clear `gnt`.
  - `req[o]`=1 and `cnt`==`MAX_BURST` and another `req` is high (forced rotation): `ptr`←`o+1`, re-arbitrate excluding `o`, set `cnt`←1.
  - `req[o]`=1 and `cnt`==`MAX_BURST` and no other request: keep the grant and set `cnt`←1.
  - Otherwise: keep the grant and set `cnt`←`cnt+1`.
- `s1`/`s0` change only when the grant changes. They hold their last value in IDLE.
- Data path: `y`←mux(`a`..`d`, `{s1,s0}`) and `y_valid`←(state==BUSY) every cycle. In IDLE, `y` holds its previous value and `y_valid`=0.
- `cnt` is ceil(log2(MAX_BURST+1)) bits wide and never exceeds `MAX_BURST`.
- With `MAX_BURST`=1, the grant rotates every cycle whenever there is contention.

## Timing
- Reset (asynchronous, immediate): `gnt`=0, `s1`=0, `s0`=0, `y`=0, `y_valid`=0, `ptr`=0, `cnt`=0, state IDLE.
- On `rst_n` deassertion, the first arbitration uses `ptr`=0.
- Grant latency: a `req` sampled high at edge k yields `gnt` and select at edge k+1.
- Data latency: `y` at edge k+1 equals the owner's input sampled at edge k while `{s1,s0}` points at that owner. `y_valid` lags `gnt` by one cycle.
- Release latency: `req[o]` sampled low at edge k removes `gnt[o]` at k+1. The next owner's `gnt` appears at the same k+1 edge.
- Simultaneous release and new request: the new request is honoured in the same evaluation.
- Reset asserted mid-burst: outputs clear immediately. The burst is not resumed.
- A requester dropping and re-raising `req` loses its slot and competes again from the current `ptr`.

## Test plan
- Reset values: hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `{s1,s0}`=00, `y`=0, `y_valid`=0. Release reset → next edge `gnt`=4'b0001.
- Single requester: `req`=4'b0100, `c`=1, others 0 → `gnt`=4'b0100 after 1 edge, `{s1,s0}`=10, `y`=1 with `y_valid`=1 one edge later. Drop `req` → `gnt`=0, then `y_valid`=0.
- Round robin under full contention, `MAX_BURST`=2, `req`=4'b1111 → owner sequence 0,0,1,1,2,2,3,3,0, each with matching select and no idle cycle.
- Solo burst renewal: `req`=4'b0010 held for 20 cycles with `MAX_BURST`=8 → `gnt` stays 4'b0010 throughout and `cnt` wraps 8→1.
- Zero-bubble handoff: owner 1 drops `req` while `req[3]`=1 → next edge `gnt`=4'b1000, `{s1,s0}`=11, `y_valid` continuously 1.
- Asynchronous reset mid-burst: `rst_n` pulled low between edges while `gnt`=4'b0100 → all outputs 0 immediately. After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path with a bounded burst length.
// Owns the select lines and registers the selected requester data onto y.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        gnt,
    output logic              s1,
    output logic              s0,
    output logic [DATA_W-1:0] y,
    output logic              y_valid
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        own_q, own_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        others;
    logic [1:0]        own_nxt;
    logic [DATA_W-1:0] y_p1;
    logic              vld_p1;

    // First requester found scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [DATA_W-1:0] mux4(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] i0,
                                               input logic [DATA_W-1:0] i1,
                                               input logic [DATA_W-1:0] i2,
                                               input logic [DATA_W-1:0] i3);
        logic [DATA_W-1:0] o;
        o = i0;
        case (sel)
            2'd0: o = i0;
            2'd1: o = i1;
            2'd2: o = i2;
            2'd3: o = i3;
        endcase
        return o;
    endfunction

    assign others  = req & ~(4'b0001 << own_q);
    assign own_nxt = own_q + 2'd1;

    // Stage p0: arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            own_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    own_d   = rr_pick(req, ptr_q);
                    cnt_d   = CNT_ONE;
                end
            end
            BUSY: begin
                if (!req[own_q]) begin
                    ptr_d = own_nxt;
                    if (|others) begin
                        own_d = rr_pick(others, own_nxt);
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_ONE;
                    if (|others) begin
                        ptr_d = own_nxt;
                        own_d = rr_pick(others, own_nxt);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state_q == BUSY) begin
            gnt = 4'b0001 << own_q;
        end
        {s1, s0} = own_q;
    end

    // Stage p1: registered mux output, valid lags the grant by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state_q == BUSY);
            if (state_q == BUSY) begin
                y_p1 <= mux4(own_q, a, b, c, d);
            end
        end
    end

    assign y       = y_p1;
    assign y_valid = vld_p1;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (MAX_BURST 8, 2, 1) share stimulus;
// directed scenarios plus a randomized run against a behavioural model.
module tb_mux4_rr_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       din [4];
    logic [2:0][3:0]  gnt_o;
    logic [2:0]       s1_o;
    logic [2:0]       s0_o;
    logic [2:0][3:0]  y_o;
    logic [2:0]       yv_o;

    int errors = 0;
    int checks = 0;

    int mb_tab [3] = '{8, 2, 1};

    int         m_busy [3];
    int         m_own  [3];
    int         m_ptr  [3];
    int         m_cnt  [3];
    int         m_vld  [3];
    logic [3:0] m_y    [3];

    mux4_rr_arbiter #(.DATA_W(4), .MAX_BURST(8)) u_mb8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
        .gnt(gnt_o[0]), .s1(s1_o[0]), .s0(s0_o[0]), .y(y_o[0]), .y_valid(yv_o[0])
    );

    mux4_rr_arbiter #(.DATA_W(4), .MAX_BURST(2)) u_mb2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
        .gnt(gnt_o[1]), .s1(s1_o[1]), .s0(s0_o[1]), .y(y_o[1]), .y_valid(yv_o[1])
    );

    mux4_rr_arbiter #(.DATA_W(4), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
        .gnt(gnt_o[2]), .s1(s1_o[2]), .s0(s0_o[2]), .y(y_o[2]), .y_valid(yv_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_busy[n] = 0; m_own[n] = 0; m_ptr[n] = 0;
            m_cnt[n]  = 0; m_vld[n] = 0; m_y[n]   = 4'h0;
        end
    endtask

    task automatic model_step();
        logic [3:0] oth;
        int o;
        for (int n = 0; n < 3; n++) begin
            if (m_busy[n] != 0) m_y[n] = din[m_own[n]];
            m_vld[n] = m_busy[n];
            if (m_busy[n] == 0) begin
                if (req != 4'b0000) begin
                    m_own[n]  = first_from(req, m_ptr[n]);
                    m_busy[n] = 1;
                    m_cnt[n]  = 1;
                end
            end else begin
                o = m_own[n];
                oth = req;
                oth[o] = 1'b0;
                if (!req[o]) begin
                    m_ptr[n] = (o + 1) % 4;
                    if (oth != 4'b0000) begin
                        m_own[n] = first_from(oth, m_ptr[n]);
                        m_cnt[n] = 1;
                    end else begin
                        m_busy[n] = 0;
                    end
                end else if (m_cnt[n] == mb_tab[n]) begin
                    m_cnt[n] = 1;
                    if (oth != 4'b0000) begin
                        m_ptr[n] = (o + 1) % 4;
                        m_own[n] = first_from(oth, m_ptr[n]);
                    end
                end else begin
                    m_cnt[n] = m_cnt[n] + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        din   = '{4'h5, 4'h6, 4'h7, 4'h8};
        cyc();
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0000 || {s1_o[n], s0_o[n]} !== 2'b00 ||
                y_o[n] !== 4'h0 || yv_o[n] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold inst=%0d gnt=%b sel=%b y=%h vld=%b want 0000/00/0/0",
                         n, gnt_o[n], {s1_o[n], s0_o[n]}, y_o[n], yv_o[n]);
            end
        end
        rst_n = 1'b1;
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0001 || {s1_o[n], s0_o[n]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_first_grant inst=%0d gnt=%b sel=%b want 0001/00",
                         n, gnt_o[n], {s1_o[n], s0_o[n]});
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        din = '{4'h0, 4'h0, 4'h9, 4'h0};
        req = 4'b0100;
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0100 || {s1_o[n], s0_o[n]} !== 2'b10 || yv_o[n] !== 1'b0) begin
                errors++;
                $display("FAIL single_grant inst=%0d gnt=%b sel=%b vld=%b want 0100/10/0",
                         n, gnt_o[n], {s1_o[n], s0_o[n]}, yv_o[n]);
            end
        end
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0100 || y_o[n] !== 4'h9 || yv_o[n] !== 1'b1) begin
                errors++;
                $display("FAIL single_data inst=%0d gnt=%b y=%h vld=%b want 0100/9/1",
                         n, gnt_o[n], y_o[n], yv_o[n]);
            end
        end
        req = 4'b0000;
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0000 || yv_o[n] !== 1'b1 || {s1_o[n], s0_o[n]} !== 2'b10) begin
                errors++;
                $display("FAIL single_release inst=%0d gnt=%b vld=%b sel=%b want 0000/1/10",
                         n, gnt_o[n], yv_o[n], {s1_o[n], s0_o[n]});
            end
        end
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (yv_o[n] !== 1'b0 || y_o[n] !== 4'h9 || {s1_o[n], s0_o[n]} !== 2'b10) begin
                errors++;
                $display("FAIL single_idle inst=%0d vld=%b y=%h sel=%b want 0/9/10",
                         n, yv_o[n], y_o[n], {s1_o[n], s0_o[n]});
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [3][9];
        logic [3:0] eg;
        seq[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        seq[1] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        seq[2] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        do_reset();
        din = '{4'h1, 4'h2, 4'h3, 4'h4};
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            cyc();
            for (int n = 0; n < 3; n++) begin
                eg = 4'b0000;
                eg[seq[n][k]] = 1'b1;
                checks++;
                if (gnt_o[n] !== eg || {s1_o[n], s0_o[n]} !== 2'(seq[n][k])) begin
                    errors++;
                    $display("FAIL rr_owner inst=%0d step=%0d gnt=%b sel=%b want %b/%0d",
                             n, k, gnt_o[n], {s1_o[n], s0_o[n]}, eg, seq[n][k]);
                end
                if (k > 0) begin
                    checks++;
                    if (yv_o[n] !== 1'b1 || y_o[n] !== din[seq[n][k-1]]) begin
                        errors++;
                        $display("FAIL rr_data inst=%0d step=%0d y=%h vld=%b want %h/1",
                                 n, k, y_o[n], yv_o[n], din[seq[n][k-1]]);
                    end
                end
            end
        end
    endtask

    task automatic test_solo_burst();
        do_reset();
        din = '{4'h0, 4'hA, 4'h0, 4'h0};
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            cyc();
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (gnt_o[n] !== 4'b0010 || {s1_o[n], s0_o[n]} !== 2'b01) begin
                    errors++;
                    $display("FAIL solo_burst inst=%0d step=%0d gnt=%b sel=%b want 0010/01",
                             n, k, gnt_o[n], {s1_o[n], s0_o[n]});
                end
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        din = '{4'h1, 4'hB, 4'h3, 4'hD};
        req = 4'b0010;
        cyc();
        req = 4'b1010;
        cyc();
        checks++;
        if (gnt_o[0] !== 4'b0010 || yv_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL handoff_hold gnt=%b vld=%b want 0010/1", gnt_o[0], yv_o[0]);
        end
        req = 4'b1000;
        cyc();
        checks++;
        if (gnt_o[0] !== 4'b1000 || {s1_o[0], s0_o[0]} !== 2'b11 || yv_o[0] !== 1'b1 ||
            y_o[0] !== 4'hB) begin
            errors++;
            $display("FAIL handoff_switch gnt=%b sel=%b vld=%b y=%h want 1000/11/1/b",
                     gnt_o[0], {s1_o[0], s0_o[0]}, yv_o[0], y_o[0]);
        end
        cyc();
        checks++;
        if (gnt_o[0] !== 4'b1000 || yv_o[0] !== 1'b1 || y_o[0] !== 4'hD) begin
            errors++;
            $display("FAIL handoff_data gnt=%b vld=%b y=%h want 1000/1/d",
                     gnt_o[0], yv_o[0], y_o[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        din = '{4'h1, 4'h2, 4'hC, 4'h4};
        req = 4'b0010;
        cyc();
        req = 4'b0100;
        cyc();
        cyc();
        checks++;
        if (gnt_o[0] !== 4'b0100 || y_o[0] !== 4'hC) begin
            errors++;
            $display("FAIL async_pre gnt=%b y=%h want 0100/c", gnt_o[0], y_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0000 || {s1_o[n], s0_o[n]} !== 2'b00 ||
                y_o[n] !== 4'h0 || yv_o[n] !== 1'b0) begin
                errors++;
                $display("FAIL async_clear inst=%0d gnt=%b sel=%b y=%h vld=%b want 0000/00/0/0",
                         n, gnt_o[n], {s1_o[n], s0_o[n]}, y_o[n], yv_o[n]);
            end
        end
        @(negedge clk);
        req   = 4'b1111;
        rst_n = 1'b1;
        cyc();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (gnt_o[n] !== 4'b0001 || {s1_o[n], s0_o[n]} !== 2'b00) begin
                errors++;
                $display("FAIL async_restart inst=%0d gnt=%b sel=%b want 0001/00",
                         n, gnt_o[n], {s1_o[n], s0_o[n]});
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        model_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                din[i] = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                eg = 4'b0000;
                if (m_busy[n] != 0) eg[m_own[n]] = 1'b1;
                checks++;
                if (gnt_o[n] !== eg || {s1_o[n], s0_o[n]} !== 2'(m_own[n])) begin
                    errors++;
                    $display("FAIL rand_grant inst=%0d cyc=%0d gnt=%b sel=%b want %b/%0d",
                             n, k, gnt_o[n], {s1_o[n], s0_o[n]}, eg, m_own[n]);
                end
                checks++;
                if (yv_o[n] !== 1'(m_vld[n]) || y_o[n] !== m_y[n]) begin
                    errors++;
                    $display("FAIL rand_data inst=%0d cyc=%0d y=%h vld=%b want %h/%0d",
                             n, k, y_o[n], yv_o[n], m_y[n], m_vld[n]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = '{4'h0, 4'h0, 4'h0, 4'h0};
        test_reset();
        test_single();
        test_round_robin();
        test_solo_burst();
        test_handoff();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
